// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall controller: memory FSM encoding,
// register index width and the register-compare helper.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

  function automatic logic reg_hit(input logic             used,
                                   input logic [REG_W-1:0] src,
                                   input logic [REG_W-1:0] dest);
    return used & (src == dest);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Purely combinational RAW hazard detection between the ID sources and the
// EXE/MEM destinations, with and without a forwarding unit.
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic             fwd_en_i,
  input  logic [REG_W-1:0] id_src1_i,
  input  logic [REG_W-1:0] id_src2_i,
  input  logic             id_two_src_i,
  input  logic             id_src_valid_i,
  input  logic             exe_wb_en_i,
  input  logic [REG_W-1:0] exe_dest_i,
  input  logic             exe_mem_r_en_i,
  input  logic             mem_wb_en_i,
  input  logic [REG_W-1:0] mem_dest_i,
  input  logic             branch_taken_i,
  output logic             hazard_o
);

  logic exe_hit;
  logic mem_hit;

  always_comb begin
    exe_hit = reg_hit(id_src_valid_i, id_src1_i, exe_dest_i)
            | reg_hit(id_two_src_i,   id_src2_i, exe_dest_i);
    mem_hit = reg_hit(id_src_valid_i, id_src1_i, mem_dest_i)
            | reg_hit(id_two_src_i,   id_src2_i, mem_dest_i);
    hazard_o = 1'b0;
    if (!branch_taken_i) begin
      // With forwarding only a load in EXE cannot be bypassed in time.
      if (fwd_en_i) hazard_o = exe_hit & exe_wb_en_i & exe_mem_r_en_i;
      else          hazard_o = (exe_hit & exe_wb_en_i) | (mem_hit & mem_wb_en_i);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: hazard stalls, branch flush, SRAM request/ready FSM with
// timeout, and a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_en,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             id_src_valid,
  input  logic             exe_wb_en,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_mem_r_en,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             branch_taken,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic             sram_ready,
  output logic             sram_req,
  output logic             if_freeze,
  output logic             id_bubble,
  output logic             flush,
  output logic             pipe_freeze,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  mem_state_e     state_q, state_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic           hazard;
  logic           mem_req;

  hazard_detect u_hazard_detect (
    .fwd_en_i       (fwd_en),
    .id_src1_i      (id_src1),
    .id_src2_i      (id_src2),
    .id_two_src_i   (id_two_src),
    .id_src_valid_i (id_src_valid),
    .exe_wb_en_i    (exe_wb_en),
    .exe_dest_i     (exe_dest),
    .exe_mem_r_en_i (exe_mem_r_en),
    .mem_wb_en_i    (mem_wb_en),
    .mem_dest_i     (mem_dest),
    .branch_taken_i (branch_taken),
    .hazard_o       (hazard)
  );

  always_comb begin
    mem_req     = mem_r_en | mem_w_en;
    state_d     = state_q;
    tmo_d       = tmo_q;
    mem_err_d   = mem_err_q;
    sram_req    = 1'b0;
    pipe_freeze = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_req) begin
          sram_req    = 1'b1;
          pipe_freeze = 1'b1;
          state_d     = BUSY;
          tmo_d       = '0;
        end
      end
      BUSY: begin
        sram_req = 1'b1;
        if (sram_ready) begin
          state_d = IDLE;
        end else if (tmo_q == TMO_LAST) begin
          // Abandon the access: release the pipeline and latch the error.
          mem_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          pipe_freeze = 1'b1;
          tmo_d       = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if_freeze = hazard | pipe_freeze;
    id_bubble = hazard & ~pipe_freeze;
    flush     = branch_taken & ~pipe_freeze;
    stall_d   = stall_q;
    if (if_freeze && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tmo_q     <= '0;
      mem_err_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      mem_err_q <= mem_err_d;
      stall_q   <= stall_d;
    end
  end

  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a short memory timeout.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fwd_en, id_two_src, id_src_valid, exe_wb_en, exe_mem_r_en;
  logic        mem_wb_en, branch_taken, mem_r_en, mem_w_en, sram_ready;
  logic [3:0]  id_src1, id_src2, exe_dest, mem_dest;
  logic        sram_req, if_freeze, id_bubble, flush, pipe_freeze, mem_err;
  logic [15:0] stall_cycles;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .fwd_en       (fwd_en),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_two_src   (id_two_src),
    .id_src_valid (id_src_valid),
    .exe_wb_en    (exe_wb_en),
    .exe_dest     (exe_dest),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_wb_en    (mem_wb_en),
    .mem_dest     (mem_dest),
    .branch_taken (branch_taken),
    .mem_r_en     (mem_r_en),
    .mem_w_en     (mem_w_en),
    .sram_ready   (sram_ready),
    .sram_req     (sram_req),
    .if_freeze    (if_freeze),
    .id_bubble    (id_bubble),
    .flush        (flush),
    .pipe_freeze  (pipe_freeze),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles)
  );

  typedef struct {
    logic       fwd, v1;
    logic [3:0] s1;
    logic       two;
    logic [3:0] s2;
    logic       ewb;
    logic [3:0] ed;
    logic       eld, mwb;
    logic [3:0] md;
    logic       br, hz;
  } hz_vec_t;

  hz_vec_t tbl [13] = '{
    '{1'b0,1'b1,4'd3, 1'b0,4'd0,1'b1,4'd3, 1'b0,1'b0,4'd0,1'b0,1'b1}, // exe match
    '{1'b0,1'b1,4'd3, 1'b0,4'd0,1'b1,4'd4, 1'b0,1'b0,4'd0,1'b0,1'b0}, // exe_dest differs
    '{1'b0,1'b1,4'd3, 1'b0,4'd0,1'b0,4'd3, 1'b0,1'b0,4'd0,1'b0,1'b0}, // exe not writing
    '{1'b0,1'b1,4'd3, 1'b0,4'd0,1'b0,4'd0, 1'b0,1'b1,4'd3,1'b0,1'b1}, // mem match
    '{1'b0,1'b0,4'd3, 1'b1,4'd7,1'b0,4'd0, 1'b0,1'b1,4'd7,1'b0,1'b1}, // src2 vs mem
    '{1'b0,1'b0,4'd3, 1'b0,4'd7,1'b0,4'd0, 1'b0,1'b1,4'd7,1'b0,1'b0}, // src2 unused
    '{1'b1,1'b1,4'd3, 1'b0,4'd0,1'b1,4'd3, 1'b0,1'b0,4'd0,1'b0,1'b0}, // fwd, not a load
    '{1'b1,1'b1,4'd3, 1'b0,4'd0,1'b1,4'd3, 1'b1,1'b0,4'd0,1'b0,1'b1}, // load-use
    '{1'b1,1'b1,4'd3, 1'b0,4'd0,1'b0,4'd0, 1'b0,1'b1,4'd3,1'b0,1'b0}, // fwd covers mem
    '{1'b1,1'b0,4'd0, 1'b1,4'd5,1'b1,4'd5, 1'b1,1'b0,4'd0,1'b0,1'b1}, // load-use src2
    '{1'b1,1'b1,4'd0, 1'b0,4'd5,1'b1,4'd5, 1'b1,1'b0,4'd0,1'b0,1'b0}, // src2 unused
    '{1'b0,1'b1,4'd15,1'b0,4'd0,1'b1,4'd15,1'b0,1'b0,4'd0,1'b0,1'b1}, // R15 like others
    '{1'b0,1'b1,4'd3, 1'b0,4'd0,1'b1,4'd3, 1'b0,1'b0,4'd0,1'b1,1'b0}  // branch kills hazard
  };

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fwd_en = 1'b0; id_src1 = '0; id_src2 = '0; id_two_src = 1'b0;
    id_src_valid = 1'b0; exe_wb_en = 1'b0; exe_dest = '0; exe_mem_r_en = 1'b0;
    mem_wb_en = 1'b0; mem_dest = '0; branch_taken = 1'b0;
    mem_r_en = 1'b0; mem_w_en = 1'b0; sram_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vec_cnt++;
      if ({sram_req, if_freeze, id_bubble, flush, pipe_freeze, mem_err} !== 6'b0) begin
        err_cnt++;
        $display("FAIL reset_outputs cycle %0d: got %b want 000000", i,
                 {sram_req, if_freeze, id_bubble, flush, pipe_freeze, mem_err});
      end
      vec_cnt++;
      if (stall_cycles !== 16'd0) begin
        err_cnt++;
        $display("FAIL reset_stall cycle %0d: got %0d want 0", i, stall_cycles);
      end
    end
  endtask

  task automatic test_hazard();
    do_reset();
    for (int i = 0; i < 13; i++) begin
      fwd_en = tbl[i].fwd; id_src_valid = tbl[i].v1; id_src1 = tbl[i].s1;
      id_two_src = tbl[i].two; id_src2 = tbl[i].s2; exe_wb_en = tbl[i].ewb;
      exe_dest = tbl[i].ed; exe_mem_r_en = tbl[i].eld; mem_wb_en = tbl[i].mwb;
      mem_dest = tbl[i].md; branch_taken = tbl[i].br;
      #1;
      vec_cnt++;
      if ({if_freeze, id_bubble, flush} !== {tbl[i].hz, tbl[i].hz, tbl[i].br}) begin
        err_cnt++;
        $display("FAIL hazard_vec %0d: {if_freeze,id_bubble,flush} got %b want %b", i,
                 {if_freeze, id_bubble, flush}, {tbl[i].hz, tbl[i].hz, tbl[i].br});
      end
      tick();
    end
    clear_inputs();
    #1;
    vec_cnt++;
    if (stall_cycles !== 16'd6) begin
      err_cnt++;
      $display("FAIL hazard_stall_count: got %0d want 6", stall_cycles);
    end
  endtask

  task automatic test_mem_stall();
    logic [1:0] exp_rf [4] = '{2'b11, 2'b11, 2'b11, 2'b10};
    do_reset();
    mem_r_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        sram_ready = 1'b1;
        mem_r_en   = 1'b0;
      end
      #1;
      vec_cnt++;
      if ({sram_req, pipe_freeze} !== exp_rf[i] || if_freeze !== exp_rf[i][0]) begin
        err_cnt++;
        $display("FAIL mem_stall cycle %0d: req,freeze,if_freeze got %b%b%b want %b%b",
                 i, sram_req, pipe_freeze, if_freeze, exp_rf[i], exp_rf[i][0]);
      end
      tick();
    end
    sram_ready = 1'b0;
    #1;
    vec_cnt++;
    if ({sram_req, pipe_freeze, stall_cycles} !== {2'b00, 16'd3}) begin
      err_cnt++;
      $display("FAIL mem_stall_done: req=%b freeze=%b stall=%0d want 0 0 3",
               sram_req, pipe_freeze, stall_cycles);
    end
    sram_ready = 1'b1;
    #1;
    vec_cnt++;
    if (sram_req !== 1'b0) begin
      err_cnt++;
      $display("FAIL ready_in_idle: sram_req got %b want 0", sram_req);
    end
    tick();
    sram_ready = 1'b0;
    #1;
    vec_cnt++;
    if ({sram_req, pipe_freeze} !== 2'b00) begin
      err_cnt++;
      $display("FAIL ready_in_idle_after: got %b want 00", {sram_req, pipe_freeze});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mem_w_en = 1'b1;
    tick();
    sram_ready = 1'b1;
    #1;
    vec_cnt++;
    if ({sram_req, pipe_freeze} !== 2'b10) begin
      err_cnt++;
      $display("FAIL b2b_first_release: got %b want 10", {sram_req, pipe_freeze});
    end
    tick();
    sram_ready = 1'b0;
    #1;
    vec_cnt++;
    if ({sram_req, pipe_freeze} !== 2'b11) begin
      err_cnt++;
      $display("FAIL b2b_reentry: got %b want 11", {sram_req, pipe_freeze});
    end
    tick();
    mem_w_en   = 1'b0;
    sram_ready = 1'b1;
    #1;
    vec_cnt++;
    if ({sram_req, pipe_freeze} !== 2'b10) begin
      err_cnt++;
      $display("FAIL b2b_second_release: got %b want 10", {sram_req, pipe_freeze});
    end
    tick();
    sram_ready = 1'b0;
    #1;
    vec_cnt++;
    if ({sram_req, pipe_freeze, stall_cycles} !== {2'b00, 16'd2}) begin
      err_cnt++;
      $display("FAIL b2b_idle: req=%b freeze=%b stall=%0d want 0 0 2",
               sram_req, pipe_freeze, stall_cycles);
    end
  endtask

  task automatic test_branch_stall();
    logic [2:0] exp_ffb [4] = '{3'b010, 3'b010, 3'b100, 3'b000};
    do_reset();
    mem_r_en     = 1'b1;
    branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) mem_r_en = 1'b0;
      if (i == 2) sram_ready = 1'b1;
      if (i == 3) begin
        sram_ready   = 1'b0;
        branch_taken = 1'b0;
      end
      #1;
      vec_cnt++;
      if ({flush, pipe_freeze, id_bubble} !== exp_ffb[i]) begin
        err_cnt++;
        $display("FAIL branch_stall cycle %0d: {flush,freeze,bubble} got %b want %b",
                 i, {flush, pipe_freeze, id_bubble}, exp_ffb[i]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    mem_r_en = 1'b1;
    tick();
    mem_r_en = 1'b0;
    id_src_valid = 1'b1; id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
    #1;
    vec_cnt++;
    if ({sram_req, if_freeze, id_bubble} !== 3'b110) begin
      err_cnt++;
      $display("FAIL hazard_in_busy: {req,if_freeze,bubble} got %b want 110",
               {sram_req, if_freeze, id_bubble});
    end
    clear_inputs();
    rst = 1'b1;
    tick();
    vec_cnt++;
    if ({sram_req, pipe_freeze, stall_cycles} !== {2'b00, 16'd0}) begin
      err_cnt++;
      $display("FAIL reset_mid_busy: req=%b freeze=%b stall=%0d want 0 0 0",
               sram_req, pipe_freeze, stall_cycles);
    end
    rst = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    mem_r_en = 1'b1;
    tick();
    mem_r_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      vec_cnt++;
      if ({sram_req, pipe_freeze, mem_err} !== {1'b1, (i != 4), 1'b0}) begin
        err_cnt++;
        $display("FAIL timeout_busy cycle %0d: {req,freeze,err} got %b want %b", i,
                 {sram_req, pipe_freeze, mem_err}, {1'b1, (i != 4), 1'b0});
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      vec_cnt++;
      if ({sram_req, pipe_freeze, mem_err} !== 3'b001) begin
        err_cnt++;
        $display("FAIL timeout_sticky %0d: {req,freeze,err} got %b want 001", i,
                 {sram_req, pipe_freeze, mem_err});
      end
      tick();
    end
    vec_cnt++;
    if (stall_cycles !== 16'd4) begin
      err_cnt++;
      $display("FAIL timeout_stall_count: got %0d want 4", stall_cycles);
    end
    do_reset();
    vec_cnt++;
    if (mem_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL timeout_cleared: mem_err got %b want 0", mem_err);
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_hazard();
    test_mem_stall();
    test_back_to_back();
    test_branch_stall();
    test_reset_mid_busy();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
